// File: rtl/board_display_ctrl_pkg.sv
// Shared definitions for the board display controller: FSM encoding,
// board geometry and the vertical-blank line shared with the VGA timing.
package board_display_ctrl_pkg;

  localparam int TILE_W  = 4;
  localparam int NTILES  = 16;
  localparam int BOARD_W = TILE_W * NTILES;

  // First vc value outside the visible area; vblank starts here at hc == 0.
  localparam int VB_LINE = 480;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_COMMIT  = 2'd2
  } disp_state_e;

  // One-hot highlight mask for a spawned tile, or all-zero when nothing spawned.
  function automatic logic [NTILES-1:0] spawn_onehot(input logic en, input logic [3:0] idx);
    logic [NTILES-1:0] mask;
    mask = {NTILES{1'b0}};
    if (en) begin
      mask[idx] = 1'b1;
    end else begin
      mask = {NTILES{1'b0}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/board_display_ctrl_flash_timer.sv
// Spawn highlight timer: holds the highlight mask for a number of vblank
// starts after each commit, then clears it on the vblank that expires it.
module board_display_ctrl_flash_timer
  import board_display_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [7:0]        load_val,
  input  logic              vb_start,
  input  logic [NTILES-1:0] spawn_mask,
  output logic [NTILES-1:0] flash
);

  logic [7:0]        cnt_r;
  logic [NTILES-1:0] flash_r;

  // Reload on commit; otherwise count down one per vblank and drop the mask at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r   <= 8'd0;
      flash_r <= {NTILES{1'b0}};
    end else if (load) begin
      cnt_r   <= load_val;
      flash_r <= spawn_mask;
    end else if (vb_start && (cnt_r != 8'd0)) begin
      cnt_r <= cnt_r - 8'd1;
      if (cnt_r == 8'd1) begin
        flash_r <= {NTILES{1'b0}};
      end else begin
        flash_r <= flash_r;
      end
    end else begin
      cnt_r   <= cnt_r;
      flash_r <= flash_r;
    end
  end

  assign flash = flash_r;

endmodule

// File: rtl/board_display_ctrl.sv
// Frame-synchronous owner of the 4x4 board image. Accepts one board update
// at a time into a shadow buffer and commits it just after vblank start, so
// a visible frame never shows a half-updated board. Also drives the spawn
// highlight mask and a free-running frame counter.
module board_display_ctrl
  import board_display_ctrl_pkg::*;
#(
  parameter int V_VISIBLE    = VB_LINE,
  parameter int FLASH_FRAMES = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [9:0]         hc,
  input  logic [9:0]         vc,
  input  logic               upd_valid,
  output logic               upd_ready,
  input  logic [BOARD_W-1:0] upd_board,
  input  logic               upd_spawn_en,
  input  logic [3:0]         upd_spawn_idx,
  output logic [BOARD_W-1:0] disp_board,
  output logic [NTILES-1:0]  disp_flash,
  output logic               commit_pulse,
  output logic [15:0]        frame_cnt
);

  disp_state_e        state_r;
  logic               upd_ready_r;
  logic               commit_pulse_r;
  logic [BOARD_W-1:0] shadow_r;
  logic               spawn_en_r;
  logic [3:0]         spawn_idx_r;
  logic [BOARD_W-1:0] disp_board_r;
  logic [15:0]        frame_cnt_r;
  logic               vb_start_s;
  logic               commit_load_s;
  logic [NTILES-1:0]  spawn_mask_s;

  // Out-of-range counter values can never equal these constants, so they are ignored.
  assign vb_start_s    = (vc == 10'(V_VISIBLE)) && (hc == 10'd0);
  assign commit_load_s = (state_r == ST_COMMIT);
  assign spawn_mask_s  = spawn_onehot(spawn_en_r, spawn_idx_r);

  // Update FSM: capture into the shadow, wait for vblank, commit for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      upd_ready_r    <= 1'b1;
      commit_pulse_r <= 1'b0;
      shadow_r       <= {BOARD_W{1'b0}};
      spawn_en_r     <= 1'b0;
      spawn_idx_r    <= 4'd0;
      disp_board_r   <= {BOARD_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          commit_pulse_r <= 1'b0;
          if (upd_valid) begin
            shadow_r    <= upd_board;
            spawn_en_r  <= upd_spawn_en;
            spawn_idx_r <= upd_spawn_idx;
            upd_ready_r <= 1'b0;
            state_r     <= ST_PENDING;
          end else begin
            upd_ready_r <= 1'b1;
            state_r     <= ST_IDLE;
          end
        end
        ST_PENDING: begin
          upd_ready_r <= 1'b0;
          if (vb_start_s) begin
            commit_pulse_r <= 1'b1;
            state_r        <= ST_COMMIT;
          end else begin
            commit_pulse_r <= 1'b0;
            state_r        <= ST_PENDING;
          end
        end
        ST_COMMIT: begin
          disp_board_r   <= shadow_r;
          commit_pulse_r <= 1'b0;
          upd_ready_r    <= 1'b1;
          state_r        <= ST_IDLE;
        end
        default: begin
          commit_pulse_r <= 1'b0;
          upd_ready_r    <= 1'b1;
          state_r        <= ST_IDLE;
        end
      endcase
    end
  end

  // Frame counter advances on every vblank start regardless of FSM state.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_r <= 16'd0;
    end else if (vb_start_s) begin
      frame_cnt_r <= frame_cnt_r + 16'd1;
    end else begin
      frame_cnt_r <= frame_cnt_r;
    end
  end

  board_display_ctrl_flash_timer u_flash_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (commit_load_s),
    .load_val   (8'(FLASH_FRAMES)),
    .vb_start   (vb_start_s),
    .spawn_mask (spawn_mask_s),
    .flash      (disp_flash)
  );

  assign upd_ready    = upd_ready_r;
  assign commit_pulse = commit_pulse_r;
  assign disp_board   = disp_board_r;
  assign frame_cnt    = frame_cnt_r;

endmodule

// File: tb/tb_board_display_ctrl.sv
// Self-checking bench for board_display_ctrl with a transaction-level model:
// an outstanding-board flag, the cycle its commit lands, and a flash frame budget.
module tb_board_display_ctrl;

  localparam int FLASH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  hc, vc;
  logic        upd_valid, upd_ready;
  logic [63:0] upd_board, disp_board;
  logic        upd_spawn_en;
  logic [3:0]  upd_spawn_idx;
  logic [15:0] disp_flash, frame_cnt;
  logic        commit_pulse;

  always #5 clk = ~clk;

  board_display_ctrl #(.V_VISIBLE(480), .FLASH_FRAMES(FLASH)) dut (
    .clk(clk), .rst(rst), .hc(hc), .vc(vc),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_board(upd_board),
    .upd_spawn_en(upd_spawn_en), .upd_spawn_idx(upd_spawn_idx),
    .disp_board(disp_board), .disp_flash(disp_flash),
    .commit_pulse(commit_pulse), .frame_cnt(frame_cnt)
  );

  int n_pass = 0, n_total = 0;
  int cyc = 0, pulses = 0;

  // reference model state
  logic [63:0] m_board, m_shadow;
  logic        m_sen;
  logic [3:0]  m_sidx;
  bit          m_out;
  int          m_land;
  int          m_left;
  logic [15:0] m_mask, m_frames;
  bit          m_pulse;

  task automatic model_reset();
    m_board = 64'h0; m_shadow = 64'h0; m_sen = 1'b0; m_sidx = 4'd0;
    m_out = 1'b0; m_land = -1; m_left = 0; m_mask = 16'h0; m_frames = 16'h0;
  endtask

  // One clock: drive hc/vc (vblank start or a random non-matching position), advance the model.
  task automatic cycle(input bit vb);
    bit acc, out_pre, landed;
    if (vb) begin
      vc = 10'd480; hc = 10'd0;
    end else begin
      case ($urandom_range(0, 3))
        0: begin vc = 10'($urandom_range(0, 479));    hc = 10'($urandom_range(0, 1023)); end
        1: begin vc = 10'd480;                        hc = 10'($urandom_range(1, 1023)); end
        2: begin vc = 10'($urandom_range(481, 1023)); hc = 10'($urandom_range(0, 1023)); end
        default: begin vc = 10'($urandom_range(0, 479)); hc = 10'd0; end
      endcase
    end
    out_pre = m_out;
    acc = upd_valid && !m_out && !rst;
    @(posedge clk); #1;
    cyc++;
    if (commit_pulse === 1'b1) pulses++;
    landed = 1'b0;
    if (rst) begin
      model_reset();
    end else begin
      if (vb) m_frames = m_frames + 16'd1;
      if (m_land == cyc) begin
        m_board = m_shadow; m_out = 1'b0; m_land = -1; landed = 1'b1;
        m_left = FLASH;
        m_mask = m_sen ? (16'h0001 << m_sidx) : 16'h0000;
      end else if (vb && m_left > 0) begin
        m_left--;
        if (m_left == 0) m_mask = 16'h0000;
      end
      if (out_pre && vb && m_land < 0 && !landed) m_land = cyc + 1;
      if (acc) begin
        m_out = 1'b1; m_shadow = upd_board; m_sen = upd_spawn_en; m_sidx = upd_spawn_idx;
      end
    end
    m_pulse = (m_land == cyc + 1);
  endtask

  task automatic frame(input int quiet);
    repeat (quiet) cycle(1'b0);
    cycle(1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1; upd_valid = 1'b0; upd_board = 64'h0; upd_spawn_en = 1'b0; upd_spawn_idx = 4'd0;
    cycle(1'b0); cycle(1'b1);
    rst = 1'b0;
    n_total++; if (disp_board !== 64'h0) $display("FAIL reset_board got %h exp 0", disp_board); else n_pass++;
    n_total++; if (upd_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", upd_ready); else n_pass++;
    n_total++; if (disp_flash !== 16'h0) $display("FAIL reset_flash got %h exp 0", disp_flash); else n_pass++;
    n_total++; if (commit_pulse !== 1'b0) $display("FAIL reset_pulse got %b exp 0", commit_pulse); else n_pass++;
    n_total++; if (frame_cnt !== 16'h0) $display("FAIL reset_frames got %h exp 0", frame_cnt); else n_pass++;
    frame(5); frame(5);
    n_total++; if (frame_cnt !== 16'd2) $display("FAIL idle_frames got %0d exp 2", frame_cnt); else n_pass++;
    n_total++; if (disp_board !== 64'h0) $display("FAIL idle_board got %h exp 0", disp_board); else n_pass++;
    n_total++; if (disp_flash !== 16'h0) $display("FAIL idle_flash got %h exp 0", disp_flash); else n_pass++;
    n_total++; if (upd_ready !== 1'b1) $display("FAIL idle_ready got %b exp 1", upd_ready); else n_pass++;
  endtask

  task automatic test_commit_flash();
    int p0;
    logic [15:0] exp_flash;
    p0 = pulses;
    upd_board = 64'h21; upd_spawn_en = 1'b1; upd_spawn_idx = 4'd1; upd_valid = 1'b1;
    cycle(1'b0);
    upd_valid = 1'b0;
    n_total++; if (upd_ready !== 1'b0) $display("FAIL cf_ready_drop got %b exp 0", upd_ready); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0);
      n_total++; if (disp_board !== 64'h0) $display("FAIL cf_hold got %h exp 0", disp_board); else n_pass++;
    end
    cycle(1'b1);
    n_total++; if (disp_board !== 64'h0) $display("FAIL cf_vb_hold got %h exp 0", disp_board); else n_pass++;
    n_total++; if (commit_pulse !== 1'b1) $display("FAIL cf_pulse got %b exp 1", commit_pulse); else n_pass++;
    cycle(1'b0);
    n_total++; if (disp_board !== 64'h21) $display("FAIL cf_board got %h exp 21", disp_board); else n_pass++;
    n_total++; if (commit_pulse !== 1'b0) $display("FAIL cf_pulse_end got %b exp 0", commit_pulse); else n_pass++;
    n_total++; if (upd_ready !== 1'b1) $display("FAIL cf_ready_back got %b exp 1", upd_ready); else n_pass++;
    n_total++; if (disp_flash !== 16'h0002) $display("FAIL cf_flash_load got %h exp 0002", disp_flash); else n_pass++;
    n_total++; if (pulses - p0 !== 1) $display("FAIL cf_pulse_count got %0d exp 1", pulses - p0); else n_pass++;
    for (int f = 1; f <= FLASH; f++) begin
      frame(3);
      exp_flash = (f < FLASH) ? 16'h0002 : 16'h0000;
      n_total++; if (disp_flash !== exp_flash) $display("FAIL cf_flash_f%0d got %h exp %h", f, disp_flash, exp_flash); else n_pass++;
      n_total++; if (disp_flash !== m_mask) $display("FAIL cf_flash_model_f%0d got %h exp %h", f, disp_flash, m_mask); else n_pass++;
    end
  endtask

  task automatic test_vb_same_cycle();
    logic [63:0] old_b, new_b;
    logic [15:0] f0;
    old_b = m_board; f0 = m_frames;
    new_b = {$urandom, $urandom};
    upd_board = new_b; upd_spawn_en = 1'b0; upd_valid = 1'b1;
    cycle(1'b1);
    upd_valid = 1'b0;
    n_total++; if (upd_ready !== 1'b0) $display("FAIL vbs_ready got %b exp 0", upd_ready); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0);
      n_total++; if (commit_pulse !== 1'b0) $display("FAIL vbs_no_pulse got %b exp 0", commit_pulse); else n_pass++;
      n_total++; if (disp_board !== old_b) $display("FAIL vbs_hold got %h exp %h", disp_board, old_b); else n_pass++;
    end
    cycle(1'b1); cycle(1'b0);
    n_total++; if (disp_board !== new_b) $display("FAIL vbs_board got %h exp %h", disp_board, new_b); else n_pass++;
    n_total++; if (frame_cnt !== f0 + 16'd2) $display("FAIL vbs_frames got %0d exp %0d", frame_cnt, f0 + 16'd2); else n_pass++;
    n_total++; if (disp_flash !== 16'h0) $display("FAIL vbs_no_flash got %h exp 0", disp_flash); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [63:0] a, b, old_b;
    int p0;
    p0 = pulses; old_b = m_board;
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    upd_board = a; upd_spawn_en = 1'b1; upd_spawn_idx = 4'($urandom_range(0, 15)); upd_valid = 1'b1;
    cycle(1'b0);
    upd_board = b; upd_spawn_idx = 4'($urandom_range(0, 15));
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0);
      n_total++; if (upd_ready !== 1'b0) $display("FAIL b2b_ready_low got %b exp 0", upd_ready); else n_pass++;
    end
    n_total++; if (disp_board !== old_b) $display("FAIL b2b_hold got %h exp %h", disp_board, old_b); else n_pass++;
    cycle(1'b1); cycle(1'b0);
    n_total++; if (disp_board !== a) $display("FAIL b2b_board_a got %h exp %h", disp_board, a); else n_pass++;
    n_total++; if (disp_flash !== m_mask) $display("FAIL b2b_flash_a got %h exp %h", disp_flash, m_mask); else n_pass++;
    cycle(1'b0);
    upd_valid = 1'b0;
    n_total++; if (upd_ready !== 1'b0) $display("FAIL b2b_b_taken got %b exp 0", upd_ready); else n_pass++;
    repeat (3) cycle(1'b0);
    n_total++; if (disp_board !== a) $display("FAIL b2b_a_stays got %h exp %h", disp_board, a); else n_pass++;
    cycle(1'b1); cycle(1'b0);
    n_total++; if (disp_board !== b) $display("FAIL b2b_board_b got %h exp %h", disp_board, b); else n_pass++;
    n_total++; if (pulses - p0 !== 2) $display("FAIL b2b_pulses got %0d exp 2", pulses - p0); else n_pass++;
  endtask

  task automatic test_reset_pending();
    int p0;
    upd_board = 64'hDEAD_BEEF_1234_5678; upd_spawn_en = 1'b1; upd_spawn_idx = 4'd7; upd_valid = 1'b1;
    cycle(1'b0);
    upd_valid = 1'b0;
    repeat (2) cycle(1'b0);
    rst = 1'b1; cycle(1'b0); rst = 1'b0;
    n_total++; if (disp_board !== 64'h0) $display("FAIL rp_board got %h exp 0", disp_board); else n_pass++;
    n_total++; if (upd_ready !== 1'b1) $display("FAIL rp_ready got %b exp 1", upd_ready); else n_pass++;
    n_total++; if (disp_flash !== 16'h0) $display("FAIL rp_flash got %h exp 0", disp_flash); else n_pass++;
    p0 = pulses;
    frame(3); frame(3); cycle(1'b0);
    n_total++; if (pulses !== p0) $display("FAIL rp_no_commit got %0d exp %0d", pulses, p0); else n_pass++;
    n_total++; if (disp_board !== 64'h0) $display("FAIL rp_board_after got %h exp 0", disp_board); else n_pass++;
    n_total++; if (frame_cnt !== 16'd2) $display("FAIL rp_frames got %0d exp 2", frame_cnt); else n_pass++;
  endtask

  task automatic test_random();
    int gap;
    gap = $urandom_range(2, 9);
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (!upd_valid || !upd_ready) begin
        upd_valid     = ($urandom_range(0, 3) == 0);
        upd_board     = {$urandom, $urandom};
        upd_spawn_en  = $urandom_range(0, 1);
        upd_spawn_idx = 4'($urandom_range(0, 15));
      end
      if (gap == 0) begin
        cycle(1'b1);
        gap = $urandom_range(2, 9);
      end else begin
        cycle(1'b0);
        gap--;
      end
      n_total++; if (disp_board !== m_board) $display("FAIL rnd_board c%0d got %h exp %h", cyc, disp_board, m_board); else n_pass++;
      n_total++; if (upd_ready !== !m_out) $display("FAIL rnd_ready c%0d got %b exp %b", cyc, upd_ready, !m_out); else n_pass++;
      n_total++; if (commit_pulse !== m_pulse) $display("FAIL rnd_pulse c%0d got %b exp %b", cyc, commit_pulse, m_pulse); else n_pass++;
      n_total++; if (disp_flash !== m_mask) $display("FAIL rnd_flash c%0d got %h exp %h", cyc, disp_flash, m_mask); else n_pass++;
      n_total++; if (frame_cnt !== m_frames) $display("FAIL rnd_frames c%0d got %h exp %h", cyc, frame_cnt, m_frames); else n_pass++;
    end
    rst = 1'b0; upd_valid = 1'b0;
  endtask

  task automatic test_frame_wrap();
    rst = 1'b1; cycle(1'b0); rst = 1'b0;
    repeat (65535) cycle(1'b1);
    n_total++; if (frame_cnt !== 16'hFFFF) $display("FAIL wrap_max got %h exp ffff", frame_cnt); else n_pass++;
    cycle(1'b1);
    n_total++; if (frame_cnt !== 16'h0000) $display("FAIL wrap_zero got %h exp 0000", frame_cnt); else n_pass++;
  endtask

  initial begin
    rst = 1'b1; hc = 10'd0; vc = 10'd0;
    upd_valid = 1'b0; upd_board = 64'h0; upd_spawn_en = 1'b0; upd_spawn_idx = 4'd0;
    model_reset();
    test_reset();
    test_commit_flash();
    test_vb_same_cycle();
    test_back_to_back();
    test_reset_pending();
    test_random();
    test_frame_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
